// File: rtl/aes_round_seq_if.sv
// Sequencer <-> datapath/SPI control bundle for the iterative AES-128 core.
// master = sequencer, slave = datapath side (drives load). Optional perf counter under AES_SEQ_PERF_EN.
interface aes_round_seq_if;
    logic       load;
    logic [3:0] round;
    logic [7:0] rcon;
    logic       init_sel;
    logic       st_en;
    logic       rk_en;
    logic       last;
    logic       busy;
    logic       done;
`ifdef AES_SEQ_PERF_EN
    logic [7:0] perf_cycles;
`endif

    modport master (
        input  load,
        output round, rcon, init_sel, st_en, rk_en, last, busy, done
`ifdef AES_SEQ_PERF_EN
        , output perf_cycles
`endif
    );

    modport slave (
        output load,
        input  round, rcon, init_sel, st_en, rk_en, last, busy, done
`ifdef AES_SEQ_PERF_EN
        , input perf_cycles
`endif
    );
endinterface

// File: rtl/aes_round_seq.sv
// AES-128 round sequencer: steps the shared datapath through INIT plus NR rounds after load falls.
// Latency: done at falling-load edge + 1 + NR*(SBOX_LAT+1); no backpressure, load high aborts.
// Optional cycle counter output perf_cycles enabled by AES_SEQ_PERF_EN.
module aes_round_seq #(
    parameter int NR       = 10,
    parameter int SBOX_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    aes_round_seq_if.master io
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_SUB, S_UPD, S_DONE} state_t;

    localparam int           CW       = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [CW-1:0] SUB_LAST = (SBOX_LAT > 1) ? CW'(SBOX_LAT - 1) : '0;
    localparam logic [3:0]   NR_L     = 4'(NR);
    localparam state_t       STEP     = (SBOX_LAT == 0) ? S_UPD : S_SUB;

    state_t        state, state_nxt;
    logic          load_q;
    logic [3:0]    round_q;
    logic [7:0]    rcon_q;
    logic [CW-1:0] sub_cnt;
    logic          start;
    logic          round_last;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    assign start      = (state == S_LOAD) && !io.load && load_q;
    assign round_last = (round_q == NR_L);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (io.load) state_nxt = S_LOAD;
            S_LOAD: if (start)   state_nxt = S_INIT;
            S_INIT: state_nxt = io.load ? S_LOAD : STEP;
            S_SUB: begin
                if (io.load)                   state_nxt = S_LOAD;
                else if (sub_cnt == SUB_LAST)  state_nxt = S_UPD;
            end
            S_UPD: begin
                if (io.load)         state_nxt = S_LOAD;
                else if (round_last) state_nxt = S_DONE;
                else                 state_nxt = STEP;
            end
            S_DONE: if (io.load) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        io.init_sel = 1'b0;
        io.st_en    = 1'b0;
        io.rk_en    = 1'b0;
        io.last     = 1'b0;
        io.busy     = 1'b0;
        io.done     = 1'b0;
        case (state)
            S_INIT: begin
                io.init_sel = 1'b1;
                io.st_en    = 1'b1;
                io.rk_en    = 1'b1;
                io.busy     = 1'b1;
            end
            S_SUB: begin
                io.busy = 1'b1;
                io.last = round_last;
            end
            S_UPD: begin
                io.st_en = 1'b1;
                io.rk_en = 1'b1;
                io.busy  = 1'b1;
                io.last  = round_last;
            end
            S_DONE:  io.done = 1'b1;
            default: ;
        endcase
    end

    // Round/Rcon track the state transitions; entering LOAD (abort or new block) rewinds them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_q  <= 1'b0;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
            sub_cnt <= '0;
        end else begin
            load_q  <= io.load;
            sub_cnt <= (state == S_SUB && state_nxt == S_SUB) ? sub_cnt + 1'b1 : '0;
            if (state_nxt == S_LOAD) begin
                round_q <= 4'd0;
                rcon_q  <= 8'h01;
            end else if (state == S_INIT) begin
                round_q <= 4'd1;
                rcon_q  <= 8'h01;
            end else if (state == S_UPD && !round_last) begin
                round_q <= round_q + 4'd1;
                rcon_q  <= xtime(rcon_q);
            end
        end
    end

    assign io.round = round_q;
    assign io.rcon  = rcon_q;

`ifdef AES_SEQ_PERF_EN
    logic [7:0] perf_q;

    always_ff @(posedge clk) begin
        if (!reset)
            perf_q <= 8'd0;
        else if (start)
            perf_q <= 8'd0;
        else if ((state == S_INIT || state == S_SUB || state == S_UPD) && perf_q != 8'hFF)
            perf_q <= perf_q + 8'd1;
    end

    assign io.perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: two instances (SBOX_LAT=1 and 0) driving a reference AES datapath.
module tb_aes_round_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    aes_round_seq_if ifc ();
    aes_round_seq_if ifc0 ();

    aes_round_seq #(.NR(10), .SBOX_LAT(1)) u_dut  (.clk(clk), .reset(reset), .io(ifc.master));
    aes_round_seq #(.NR(10), .SBOX_LAT(0)) u_dut0 (.clk(clk), .reset(reset), .io(ifc0.master));

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference AES-128 datapath ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o;
    endfunction

    function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0] st, rk, st0, rk0;

    always @(posedge clk) begin
        if (ifc.rk_en) rk <= ifc.init_sel ? KEY : kexp(rk, ifc.rcon);
        if (ifc.st_en) st <= ifc.init_sel ? (PT ^ KEY) : (aes_round(st, ifc.last) ^ kexp(rk, ifc.rcon));
        if (ifc0.rk_en) rk0 <= ifc0.init_sel ? KEY : kexp(rk0, ifc0.rcon);
        if (ifc0.st_en) st0 <= ifc0.init_sel ? (PT ^ KEY) : (aes_round(st0, ifc0.last) ^ kexp(rk0, ifc0.rcon));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic v);
        ifc.load  = v;
        ifc0.load = v;
    endtask

    int         lat, lat0, sten, sten0, sub0, nlast, last_rnd, bad_last, n_rc;
    logic [7:0] rc_seen [16];

    // Call with load just lowered: the next edge is the start edge (k=0).
    task automatic run_measure();
        lat = -1; lat0 = -1; sten = 0; sten0 = 0; sub0 = 0;
        nlast = 0; last_rnd = -1; bad_last = 0; n_rc = 0;
        for (int k = 0; k <= 60; k++) begin
            tick();
            if (ifc.st_en) sten++;
            if (ifc.st_en && !ifc.init_sel) begin
                if (n_rc < 16) rc_seen[n_rc] = ifc.rcon;
                n_rc++;
                if (ifc.last) begin
                    nlast++;
                    last_rnd = int'(ifc.round);
                end
            end
            if (ifc.last && ifc.round != 4'd10) bad_last++;
            if (ifc0.st_en) sten0++;
            if (ifc0.busy && !ifc0.st_en) sub0++;
            if (ifc.done && lat < 0) lat = k;
            if (ifc0.done && lat0 < 0) lat0 = k;
            if (lat >= 0 && lat0 >= 0) break;
        end
    endtask

    task automatic wait_round(input logic [3:0] r, output logic hit);
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            tick();
            if (ifc.round == r && ifc.busy) hit = 1'b1;
        end
    endtask

    logic [7:0] rc_exp [10];
    logic       hit;
    int         seen;

    initial begin
        rc_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        set_load(1'b0);
        reset = 1'b0;
        repeat (2) tick();
        chk("rst_round", ifc.round, 4'd0);
        chk("rst_rcon", ifc.rcon, 8'h01);
        chk("rst_flags", {ifc.init_sel, ifc.st_en, ifc.rk_en, ifc.last, ifc.busy, ifc.done}, 6'b0);
        chk("rst_flags0", {ifc0.init_sel, ifc0.st_en, ifc0.rk_en, ifc0.last, ifc0.busy, ifc0.done}, 6'b0);
        reset = 1'b1;

        // Full encryption, both S-box latencies in parallel.
        set_load(1'b1);
        repeat (256) tick();
        chk("load_not_busy", {ifc.busy, ifc.done}, 2'b00);
        set_load(1'b0);
        run_measure();
        chk("latency", lat, 21);
        chk("st_en_count", sten, 11);
        chk("upd_count", n_rc, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("rcon_%0d", i + 1), rc_seen[i], rc_exp[i]);
        chk("last_upd_count", nlast, 1);
        chk("last_round", last_rnd, 10);
        chk("last_only_r10", bad_last, 0);
        chk("ciphertext", st, CT);
        chk("lat0", lat0, 11);
        chk("st_en_count0", sten0, 11);
        chk("sub_cycles0", sub0, 0);
        chk("ciphertext0", st0, CT);
`ifdef AES_SEQ_PERF_EN
        chk("perf", ifc.perf_cycles, 8'd21);
        chk("perf0", ifc0.perf_cycles, 8'd11);
`endif

        // done is sticky until load is sampled high, then drops on that edge.
        repeat (5) tick();
        chk("done_sticky", ifc.done, 1'b1);
        set_load(1'b1);
        tick();
        chk("done_drop", ifc.done, 1'b0);
        chk("load_round", ifc.round, 4'd0);

        // Abort at round 5, then a fresh run completes normally.
        repeat (3) tick();
        set_load(1'b0);
        tick();
        wait_round(4'd5, hit);
        chk("reach_r5", hit, 1'b1);
        set_load(1'b1);
        tick();
        chk("abort_round", ifc.round, 4'd0);
        chk("abort_rcon", ifc.rcon, 8'h01);
        chk("abort_flags", {ifc.st_en, ifc.rk_en, ifc.busy, ifc.done}, 4'b0);
        repeat (3) tick();
        chk("abort_idle", {ifc.busy, ifc.done}, 2'b00);
        set_load(1'b0);
        run_measure();
        chk("abort_relat", lat, 21);
        chk("abort_ct", st, CT);

        // Reset during round 7: reset values next edge, no done afterwards.
        set_load(1'b1);
        repeat (3) tick();
        set_load(1'b0);
        tick();
        wait_round(4'd7, hit);
        chk("reach_r7", hit, 1'b1);
        reset = 1'b0;
        tick();
        chk("mid_rst_round", ifc.round, 4'd0);
        chk("mid_rst_rcon", ifc.rcon, 8'h01);
        chk("mid_rst_flags", {ifc.init_sel, ifc.st_en, ifc.rk_en, ifc.last, ifc.busy, ifc.done}, 6'b0);
        tick();
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (ifc.done || ifc.busy) seen++;
        end
        chk("no_done_after_rst", seen, 0);

        // Sub-cycle load glitch between edges is never sampled.
        tick();
        set_load(1'b1);
        #2;
        set_load(1'b0);
        seen = 0;
        repeat (30) begin
            tick();
            if (ifc.busy || ifc.done || ifc0.busy || ifc0.done) seen++;
        end
        chk("glitch_ignored", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
